alu_issuer: RTL and testbench



---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_issuer_if.sv | 44 ++++
 rtl/issuer_regfile.sv | 25 ++
 rtl/alu_issuer.sv | 150 +++++++++++++++
 tb/tb_alu_issuer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and flag helpers for the ALU command issuer.
package alu_pkg;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_NOT = 3'b010;
  localparam logic [2:0] SEL_AND = 3'b011;
  localparam logic [2:0] SEL_OR  = 3'b100;
  localparam logic [2:0] SEL_XOR = 3'b101;
  localparam logic [2:0] SEL_SLT = 3'b110;
  localparam logic [2:0] SEL_SEQ = 3'b111;

  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_E = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // SUB, SLT and SEQ need the ALU's subtract/compare path.
  function automatic logic uses_in_c(input logic [3:0] op);
    return (op == {1'b0, SEL_SUB}) || (op == {1'b0, SEL_SLT}) || (op == {1'b0, SEL_SEQ});
  endfunction

  function automatic logic [3:0] make_flags(input logic c, input logic z, input logic v,
                                            input logic e);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_E] = e;
    return f;
  endfunction

endpackage

// File: rtl/alu_issuer_if.sv
// Command, response and ALU-side signals of the issuer, bundled for port connection.
interface alu_issuer_if;
  // Both handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; once raised, valid and its payload stay stable until that transfer.
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_rs1;
  logic [1:0] cmd_rs2;
  logic [3:0] cmd_imm;

  logic [2:0] alu_select;
  logic       alu_in_c;
  logic [3:0] alu_in_x;
  logic [3:0] alu_in_y;
  logic [3:0] alu_out_s;
  logic       alu_out_c;
  logic       alu_zero;
  logic       alu_overflow;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [3:0] rsp_flags;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output cmd_ready,
    output alu_select, alu_in_c, alu_in_x, alu_in_y,
    input  alu_out_s, alu_out_c, alu_zero, alu_overflow,
    output rsp_valid, rsp_data, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  cmd_ready,
    input  alu_select, alu_in_c, alu_in_x, alu_in_y,
    output alu_out_s, alu_out_c, alu_zero, alu_overflow,
    input  rsp_valid, rsp_data, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/issuer_regfile.sv
// 4x4-bit register file: two asynchronous read ports, one synchronous write port.
module issuer_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [3:0] wdata,
  input  logic [1:0] raddr1,
  output logic [3:0] rdata1,
  input  logic [1:0] raddr2,
  output logic [3:0] rdata2
);
  logic [3:0] mem [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'd0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

// File: rtl/alu_issuer.sv
// Command front-end for the external 4-bit ALU: issues ops, LDI and iterative MUL,
// writes results back to the register file and returns a response.
import alu_pkg::*;

module alu_issuer (
  input  logic         clk,
  input  logic         rst_n,
  alu_issuer_if.slave  bus,
  output state_t       dbg_state
);
  state_t     state, next_state;
  logic       is_mul;
  logic       sticky_c;
  logic [3:0] cnt;
  logic [1:0] rd_q;
  logic       we;
  logic [1:0] waddr;
  logic [3:0] wdata;
  logic [3:0] rs1_data, rs2_data;
  logic [2:0] alu_select;
  logic       alu_in_c;
  logic [3:0] alu_in_x, alu_in_y;
  logic [3:0] rsp_data, rsp_flags;

  issuer_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (bus.cmd_rs1),
    .rdata1 (rs1_data),
    .raddr2 (bus.cmd_rs2),
    .rdata2 (rs2_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A zero-multiplier MUL writes its (zero) product at accept and skips EXEC.
  always_comb begin
    next_state = state;
    we         = 1'b0;
    waddr      = rd_q;
    wdata      = bus.alu_out_s;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_op == OP_MUL && rs2_data == 4'd0) begin
            next_state = RESP;
            we         = 1'b1;
            waddr      = bus.cmd_rd;
            wdata      = 4'd0;
          end else if (bus.cmd_op > OP_LDI) begin
            next_state = RESP;
          end else begin
            next_state = EXEC;
          end
        end
      end
      EXEC: begin
        if (!is_mul || cnt == 4'd1) begin
          next_state = RESP;
          we         = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_mul     <= 1'b0;
      sticky_c   <= 1'b0;
      cnt        <= 4'd0;
      rd_q       <= 2'd0;
      alu_select <= SEL_ADD;
      alu_in_c   <= 1'b0;
      alu_in_x   <= 4'd0;
      alu_in_y   <= 4'd0;
      rsp_data   <= 4'd0;
      rsp_flags  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            rd_q       <= bus.cmd_rd;
            is_mul     <= 1'b0;
            sticky_c   <= 1'b0;
            cnt        <= rs2_data;
            alu_select <= SEL_ADD;
            alu_in_c   <= 1'b0;
            if (bus.cmd_op < OP_MUL) begin
              alu_select <= bus.cmd_op[2:0];
              alu_in_c   <= uses_in_c(bus.cmd_op);
              alu_in_x   <= rs1_data;
              alu_in_y   <= rs2_data;
            end else if (bus.cmd_op == OP_LDI) begin
              alu_in_x <= bus.cmd_imm;
              alu_in_y <= 4'd0;
            end else if (bus.cmd_op == OP_MUL) begin
              // x is the running accumulator, y the multiplicand; rs2 counts iterations.
              is_mul   <= 1'b1;
              alu_in_x <= 4'd0;
              alu_in_y <= rs1_data;
              if (rs2_data == 4'd0) begin
                rsp_data  <= 4'd0;
                rsp_flags <= make_flags(1'b0, 1'b1, 1'b0, 1'b0);
              end
            end else begin
              rsp_data  <= 4'd0;
              rsp_flags <= make_flags(1'b0, 1'b0, 1'b0, 1'b1);
            end
          end
        end
        EXEC: begin
          if (is_mul) begin
            alu_in_x <= bus.alu_out_s;
            cnt      <= cnt - 4'd1;
            sticky_c <= sticky_c | bus.alu_out_c;
            if (cnt == 4'd1) begin
              rsp_data  <= bus.alu_out_s;
              rsp_flags <= make_flags(sticky_c | bus.alu_out_c, bus.alu_out_s == 4'd0,
                                      1'b0, 1'b0);
            end
          end else begin
            rsp_data  <= bus.alu_out_s;
            rsp_flags <= make_flags(bus.alu_out_c, bus.alu_zero, bus.alu_overflow, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_data   = rsp_data;
  assign bus.rsp_flags  = rsp_flags;
  assign bus.alu_select = alu_select;
  assign bus.alu_in_c   = alu_in_c;
  assign bus.alu_in_x   = alu_in_x;
  assign bus.alu_in_y   = alu_in_y;
  assign dbg_state      = state;
endmodule

// File: tb/tb_alu_issuer.sv
// Randomized and directed bench for alu_issuer, with a behavioural ALU and a
// register-file/product reference model.
module tb_alu_issuer;
  import alu_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     n_checks;
  int     n_fail;
  logic [7:0] exp_q[$];
  logic [3:0] regs_m [4];

  alu_issuer_if bus ();

  alu_issuer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: SUB/compare via x + ~y + 1; with in_c set, zero means x == y.
  function automatic logic [6:0] alu_model(input logic [2:0] sel, input logic cin,
                                           input logic [3:0] x, input logic [3:0] y);
    logic [4:0] add, dif;
    logic [3:0] s;
    logic       co, z, v;
    add = {1'b0, x} + {1'b0, y};
    dif = {1'b0, x} + {1'b0, ~y} + 5'd1;
    co  = 1'b0;
    v   = 1'b0;
    s   = 4'd0;
    case (sel)
      3'd0: begin s = add[3:0]; co = add[4]; end
      3'd1: begin s = dif[3:0]; co = dif[4]; v = (x[3] != y[3]) && (dif[3] != x[3]); end
      3'd2: s = ~x;
      3'd3: s = x & y;
      3'd4: s = x | y;
      3'd5: s = x ^ y;
      3'd6: s = ($signed(x) < $signed(y)) ? 4'd1 : 4'd0;
      default: s = (x == y) ? 4'd1 : 4'd0;
    endcase
    z = cin ? (dif[3:0] == 4'd0) : (s == 4'd0);
    return {s, co, z, v};
  endfunction

  logic [6:0] alu_r;
  always_comb alu_r = alu_model(bus.alu_select, bus.alu_in_c, bus.alu_in_x, bus.alu_in_y);
  assign bus.alu_out_s    = alu_r[6:3];
  assign bus.alu_out_c    = alu_r[2];
  assign bus.alu_zero     = alu_r[1];
  assign bus.alu_overflow = alu_r[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one command, check ALU drive, latency, response and optional back-pressure.
  // Entered and left at #1 after a rising edge with the block idle.
  task automatic do_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [3:0] imm, input int hold);
    logic [3:0] a, b, data, flags, ex, ey;
    logic [2:0] esel;
    logic       ec;
    logic [6:0] r;
    int         prod, lat_exp, lat, n;
    logic [7:0] exp_v;
    a = regs_m[rs1];
    b = regs_m[rs2];
    esel = 3'd0; ec = 1'b0; ex = 4'd0; ey = 4'd0;
    if (op < 4'd8) begin
      esel = op[2:0];
      ec   = (op == 4'd1) || (op == 4'd6) || (op == 4'd7);
      ex   = a; ey = b;
      r     = alu_model(esel, ec, a, b);
      data  = r[6:3];
      flags = {r[2], r[1], r[0], 1'b0};
      lat_exp = 1;
      regs_m[rd] = data;
    end else if (op == 4'd9) begin
      ex = imm;
      data  = imm;
      flags = {1'b0, imm == 4'd0, 1'b0, 1'b0};
      lat_exp = 1;
      regs_m[rd] = data;
    end else if (op == 4'd8) begin
      ey    = a;
      prod  = int'(a) * int'(b);
      data  = 4'(prod % 16);
      flags = {prod > 15, data == 4'd0, 1'b0, 1'b0};
      lat_exp = int'(b);
      regs_m[rd] = data;
    end else begin
      data  = 4'd0;
      flags = 4'b0001;
      lat_exp = 0;
    end
    exp_q.push_back({data, flags});

    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_before_accept", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (lat_exp > 0) begin
      check("exec_state", 32'(dbg_state), 32'(EXEC));
      check("alu_select", bus.alu_select, esel);
      check("alu_in_c", bus.alu_in_c, ec);
      check("alu_in_x", bus.alu_in_x, ex);
      check("alu_in_y", bus.alu_in_y, ey);
    end
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("rsp_valid", bus.rsp_valid, 1);
    check("latency", lat, lat_exp);
    exp_v = exp_q.pop_front();
    check("rsp_data", bus.rsp_data, exp_v[7:4]);
    check("rsp_flags", bus.rsp_flags, exp_v[3:0]);
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_data", {bus.rsp_data, bus.rsp_flags}, exp_v);
      check("hold_cmd_ready", bus.cmd_ready, 0);
      check("hold_state", 32'(dbg_state), 32'(RESP));
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_cleared", bus.rsp_valid, 0);
    check("back_to_idle", bus.cmd_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp"}, {bus.rsp_data, bus.rsp_flags}, 8'h00);
    check({tag, "_alu"}, {bus.alu_select, bus.alu_in_c, bus.alu_in_x, bus.alu_in_y}, 12'h000);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4; i++) regs_m[i] = 4'd0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_rd = 2'd0; bus.cmd_rs1 = 2'd0;
    bus.cmd_rs2 = 2'd0; bus.cmd_imm = 4'd0; bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sequence
    do_cmd(4'd9, 2'd1, 2'd0, 2'd0, 4'd5, 0);   // LDI r1 = 5
    do_cmd(4'd9, 2'd2, 2'd0, 2'd0, 4'd3, 0);   // LDI r2 = 3
    do_cmd(4'd0, 2'd3, 2'd1, 2'd2, 4'd0, 0);   // ADD r3 = 8
    check("add_data_direct", regs_m[3], 4'd8);
    do_cmd(4'd1, 2'd0, 2'd2, 2'd1, 4'd0, 0);   // SUB r0 = 3 - 5 = 0xE
    do_cmd(4'd7, 2'd3, 2'd1, 2'd1, 4'd0, 0);   // SEQ r1, r1
    do_cmd(4'd8, 2'd3, 2'd1, 2'd2, 4'd0, 0);   // MUL 5 x 3 = 15
    do_cmd(4'd9, 2'd2, 2'd0, 2'd0, 4'd4, 0);   // LDI r2 = 4
    do_cmd(4'd8, 2'd3, 2'd1, 2'd2, 4'd0, 0);   // MUL 5 x 4 -> 4, carry
    do_cmd(4'd9, 2'd0, 2'd0, 2'd0, 4'd0, 0);   // LDI r0 = 0
    do_cmd(4'd8, 2'd3, 2'd1, 2'd0, 4'd0, 0);   // MUL 5 x 0
    do_cmd(4'd12, 2'd1, 2'd1, 2'd1, 4'd7, 0);  // illegal, r1 untouched
    do_cmd(4'd0, 2'd2, 2'd1, 2'd0, 4'd0, 0);   // readback r1 + r0 = 5
    do_cmd(4'd0, 2'd2, 2'd1, 2'd1, 4'd0, 5);   // back-pressure for 5 cycles
    do_cmd(4'd3, 2'd1, 2'd1, 2'd1, 4'd0, 0);   // rd == rs1

    // Random stimulus
    for (int k = 0; k < 80; k++) begin
      do_cmd(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Reset during a long MUL: r3 must stay at its reset value.
    do_cmd(4'd9, 2'd2, 2'd0, 2'd0, 4'd15, 0);
    do_cmd(4'd9, 2'd1, 2'd0, 2'd0, 4'd3, 0);
    bus.cmd_op = 4'd8; bus.cmd_rd = 2'd3; bus.cmd_rs1 = 2'd1; bus.cmd_rs2 = 2'd2;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_mul_state", 32'(dbg_state), 32'(EXEC));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    for (int i = 0; i < 4; i++) regs_m[i] = 4'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_cmd(4'd0, 2'd0, 2'd3, 2'd0, 4'd0, 0);   // readback r3 + r0 = 0
    check("r3_after_reset", regs_m[0], 4'd0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
